// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings, control bundle and per-state control lookup for mc_ctrl
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_SHIFT = 3'd6;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_MEM  = 2'd1;
  localparam logic [1:0] WD_LINK = 2'd2;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_ADDU, CLS_SUBU, CLS_SLL, CLS_JR, CLS_ORI,
    CLS_LUI, CLS_LW, CLS_SW, CLS_BEQ, CLS_J, CLS_JAL
  } cls_t;

  // pc/ir enables are split into arm bits that get qualified by mem_ready or zero downstream
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we_rdy;
    logic       pc_we_u;
    logic       pc_we_rdy;
    logic       pc_we_z;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src_b;
    logic       ext_op;
    logic [2:0] alu_op;
  } ctl_t;

  function automatic state_t exec_next(cls_t c);
    case (c)
      CLS_LW, CLS_SW:                                 return S_MEM;
      CLS_ADDU, CLS_SUBU, CLS_SLL, CLS_ORI, CLS_LUI:  return S_WB;
      default:                                        return S_FETCH;
    endcase
  endfunction

  function automatic ctl_t state_ctl(state_t s, cls_t c);
    ctl_t k;
    k = '0;
    case (s)
      S_FETCH: begin
        k.mem_req   = 1'b1;
        k.ir_we_rdy = 1'b1;
        k.pc_we_rdy = 1'b1;
        k.pc_src    = PC_PLUS4;
      end
      S_EXEC: begin
        case (c)
          CLS_ADDU: k.alu_op = ALU_ADD;
          CLS_SUBU: k.alu_op = ALU_SUB;
          CLS_SLL:  k.alu_op = ALU_SHIFT;
          CLS_ORI:  begin k.alu_src_b = 1'b1; k.alu_op = ALU_OR;    end
          CLS_LUI:  begin k.alu_src_b = 1'b1; k.alu_op = ALU_SHIFT; end
          CLS_LW, CLS_SW: begin
            k.alu_src_b = 1'b1;
            k.ext_op    = 1'b1;
            k.alu_op    = ALU_ADD;
          end
          CLS_BEQ: begin
            k.alu_op  = ALU_SUB;
            k.ext_op  = 1'b1;
            k.pc_we_z = 1'b1;
            k.pc_src  = PC_BRANCH;
          end
          CLS_J:   begin k.pc_we_u = 1'b1; k.pc_src = PC_JUMP; end
          CLS_JAL: begin
            k.pc_we_u = 1'b1;
            k.pc_src  = PC_JUMP;
            k.reg_we  = 1'b1;
            k.reg_dst = DST_RA;
            k.wd_sel  = WD_LINK;
          end
          CLS_JR:  begin k.pc_we_u = 1'b1; k.pc_src = PC_RS; end
          default: k = '0;
        endcase
      end
      S_MEM: begin
        k.mem_req = 1'b1;
        k.iord    = 1'b1;
        k.mem_we  = (c == CLS_SW);
      end
      S_WB: begin
        k.reg_we  = 1'b1;
        k.reg_dst = (c == CLS_ADDU || c == CLS_SUBU || c == CLS_SLL) ? DST_RD : DST_RT;
        k.wd_sel  = (c == CLS_LW) ? WD_MEM : WD_ALU;
      end
      default: k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - shared instruction/data memory port handshake between mc_ctrl and memory
interface mc_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mc_ctrl_dec.sv
// rtl/mc_ctrl_dec.sv - combinational op/funct to instruction class and illegal flag
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic       illegal
);

  always_comb begin
    cls     = CLS_NOP;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls = CLS_ADDU;
          FN_SUBU: cls = CLS_SUBU;
          FN_SLL:  cls = CLS_SLL;
          FN_JR:   cls = CLS_JR;
          default: illegal = 1'b1;
        endcase
      end
      OP_ORI:  cls = CLS_ORI;
      OP_LUI:  cls = CLS_LUI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_J:    cls = CLS_J;
      OP_JAL:  cls = CLS_JAL;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS-subset control FSM; MC_CTRL_ILLEGAL_TRAP_EN makes illegal ops halt with err
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  mc_ctrl_if.master          mem,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               ir_we,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic               reg_we,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wd_sel,
  output logic               alu_src_b,
  output logic               ext_op,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               err,
  output logic [2:0]         state_o
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t           state;
  cls_t             cls_q;
  ctl_t             ctl_q;
  logic [CNT_W-1:0] cnt;
  cls_t             dec_cls;
  logic             dec_illegal;
  logic             timeout;

  mc_ctrl_dec u_dec (
    .op      (op),
    .funct   (funct),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  assign timeout = (MEM_TIMEOUT > 0) && !mem.mem_ready && (cnt == CNT_W'(MEM_TIMEOUT - 1));

  // ctl_q is always loaded with the controls of the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cls_q <= CLS_NOP;
      ctl_q <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_FETCH;
          ctl_q <= state_ctl(S_FETCH, cls_q);
        end
        S_FETCH, S_MEM: begin
          if (mem.mem_ready) begin
            cnt <= '0;
            if (state == S_FETCH) begin
              state <= S_DECODE;
              ctl_q <= '0;
            end else if (cls_q == CLS_LW) begin
              state <= S_WB;
              ctl_q <= state_ctl(S_WB, cls_q);
            end else begin
              state <= S_FETCH;
              ctl_q <= state_ctl(S_FETCH, cls_q);
            end
          end else if (timeout) begin
            state <= S_HALT;
            ctl_q <= '0;
            cnt   <= '0;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DECODE: begin
          cls_q <= dec_cls;
          if (dec_illegal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            state <= S_HALT;
            ctl_q <= '0;
            err   <= 1'b1;
`else
            state <= S_FETCH;
            ctl_q <= state_ctl(S_FETCH, dec_cls);
`endif
          end else begin
            state <= S_EXEC;
            ctl_q <= state_ctl(S_EXEC, dec_cls);
          end
        end
        S_EXEC: begin
          state <= exec_next(cls_q);
          ctl_q <= state_ctl(exec_next(cls_q), cls_q);
        end
        S_WB: begin
          state <= S_FETCH;
          ctl_q <= state_ctl(S_FETCH, cls_q);
        end
        default: begin
          state <= S_HALT;
          ctl_q <= '0;
        end
      endcase
    end
  end

  assign mem.mem_req = ctl_q.mem_req;
  assign mem.mem_we  = ctl_q.mem_we;
  assign mem.iord    = ctl_q.iord;
  assign ir_we       = ctl_q.ir_we_rdy & mem.mem_ready;
  assign pc_we       = ctl_q.pc_we_u | (ctl_q.pc_we_rdy & mem.mem_ready) | (ctl_q.pc_we_z & zero);
  // an untaken branch presents the sequential select rather than the branch target
  assign pc_src      = (ctl_q.pc_we_z && !zero) ? PC_PLUS4 : ctl_q.pc_src;
  assign reg_we      = ctl_q.reg_we;
  assign reg_dst     = ctl_q.reg_dst;
  assign wd_sel      = ctl_q.wd_sel;
  assign alu_src_b   = ctl_q.alu_src_b;
  assign ext_op      = ctl_q.ext_op;
  assign alu_op      = ALUOP_W'(ctl_q.alu_op);
  assign state_o     = state;

endmodule
